// File: rtl/axi_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_pkg
//   Shared definitions for the two-port AXI4 read arbiter:
//   - state_t    : arbiter FSM encoding (IDLE / ADDR / DATA)
//   - BURST_INCR : AXI INCR burst type
//   - RESP_OKAY  : AXI OKAY response code
//   - onehot2()  : 1-bit port index to 2-bit one-hot port mask
// ---------------------------------------------------------------------------
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int NUM_PORTS = 2;

  function automatic logic [NUM_PORTS-1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
//   Two-way round-robin grant picker, purely combinational.
//   Ports:
//     req[1:0] in  : request vector (bit n = requester n)
//     last     in  : requester that won the previous arbitration
//     grant    out : index of the winning requester (0 when nothing requests)
//   On a tie the requester other than 'last' wins.
// ---------------------------------------------------------------------------
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
//   Shares one AXI4 read port (AR + R only) between two read-only requesters
//   (e.g. instruction and data cache bridges). One burst outstanding, no IDs.
//   The AR request is registered; R beats pass through combinationally to the
//   granted requester.
//
//   Ports:
//     CLK, RES                 clock, synchronous active-high reset
//     S0_AR* / S1_AR*          requester address channels (ARREADY out)
//     S0_R*  / S1_R*           requester read data channels (RREADY in)
//     M_AXI_AR*                registered address channel to memory
//     M_AXI_R*                 memory read data channel (RREADY out)
//
//   Build option:
//     ARB_FIXED_PRIO_EN        when defined, S0 always wins a tie in IDLE;
//                              otherwise ties alternate round-robin.
// ---------------------------------------------------------------------------
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_DATA_WIDTH    = 32
) (
  input  logic                       CLK,
  input  logic                       RES,
  // requester 0
  input  logic [C_ADDRESS_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                 S0_ARLEN,
  input  logic [2:0]                 S0_ARSIZE,
  input  logic [1:0]                 S0_ARBURST,
  input  logic                       S0_ARVALID,
  output logic                       S0_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S0_RDATA,
  output logic [1:0]                 S0_RRESP,
  output logic                       S0_RLAST,
  output logic                       S0_RVALID,
  input  logic                       S0_RREADY,
  // requester 1
  input  logic [C_ADDRESS_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                 S1_ARLEN,
  input  logic [2:0]                 S1_ARSIZE,
  input  logic [1:0]                 S1_ARBURST,
  input  logic                       S1_ARVALID,
  output logic                       S1_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S1_RDATA,
  output logic [1:0]                 S1_RRESP,
  output logic                       S1_RLAST,
  output logic                       S1_RVALID,
  input  logic                       S1_RREADY,
  // memory
  output logic [C_ADDRESS_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                 M_AXI_ARLEN,
  output logic [2:0]                 M_AXI_ARSIZE,
  output logic [1:0]                 M_AXI_ARBURST,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]    M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RLAST,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);

  state_t                     state;
  logic                       grant;
  logic                       rr_last;
  logic                       arvalid_q;
  logic [C_ADDRESS_WIDTH-1:0] araddr_q;
  logic [7:0]                 arlen_q;
  logic [2:0]                 arsize_q;
  logic [1:0]                 arburst_q;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] rready_vec;
  logic [NUM_PORTS-1:0] arready_vec;
  logic [NUM_PORTS-1:0] rvalid_vec;
  logic                 pick;
  logic                 take;
  logic                 in_data;
  logic                 beat_last;

  assign req        = {S1_ARVALID, S0_ARVALID};
  assign rready_vec = {S1_RREADY,  S0_RREADY};

  arb_rr2 u_pick (
    .req   (req),
    .last  (rr_last),
    .grant (pick)
  );

  // ARREADY is a same-cycle acknowledge of the IDLE grant. Gating with RES
  // keeps a request from being acknowledged while the capture is suppressed.
  assign take        = (state == ST_IDLE) && !RES && (|req);
  assign arready_vec = take ? onehot2(pick) : '0;
  assign S0_ARREADY  = arready_vec[0];
  assign S1_ARREADY  = arready_vec[1];

  // R channel: zero-latency pass-through, qualified only in DATA so stray
  // memory beats in IDLE/ADDR never reach a requester.
  assign in_data      = (state == ST_DATA);
  assign M_AXI_RREADY = in_data && rready_vec[grant];
  assign beat_last    = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

  always_comb begin
    rvalid_vec = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rvalid_vec[p] = in_data && M_AXI_RVALID && (grant == p[0]);
  end

  assign S0_RVALID = rvalid_vec[0];
  assign S1_RVALID = rvalid_vec[1];
  assign S0_RDATA  = M_AXI_RDATA;
  assign S1_RDATA  = M_AXI_RDATA;
  assign S0_RRESP  = M_AXI_RRESP;
  assign S1_RRESP  = M_AXI_RRESP;
  assign S0_RLAST  = M_AXI_RLAST;
  assign S1_RLAST  = M_AXI_RLAST;

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = arsize_q;
  assign M_AXI_ARBURST = arburst_q;
  assign M_AXI_ARVALID = arvalid_q;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= ST_IDLE;
      grant     <= 1'b0;
      rr_last   <= 1'b1;   // S0 wins the first tie
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= pick;
            araddr_q  <= pick ? S1_ARADDR  : S0_ARADDR;
            arlen_q   <= pick ? S1_ARLEN   : S0_ARLEN;
            arsize_q  <= pick ? S1_ARSIZE  : S0_ARSIZE;
            arburst_q <= pick ? S1_ARBURST : S0_ARBURST;
            arvalid_q <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Memory RLAST alone ends the burst; beats are not counted.
          if (beat_last) begin
`ifdef ARB_FIXED_PRIO_EN
            // rr_last stays at its reset value, so the picker always
            // resolves a tie in favour of S0.
            rr_last <= 1'b1;
`else
            rr_last <= grant;
`endif
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  always #5 CLK = ~CLK;

  logic [1:0]  arvalid;
  logic [1:0]  rready;
  logic [31:0] req_addr  [2];
  logic [7:0]  req_len   [2];
  logic [2:0]  req_size  [2];
  logic [1:0]  req_burst [2];

  logic        S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST;
  logic [31:0] S0_RDATA, S1_RDATA;
  logic [1:0]  S0_RRESP, S1_RRESP;

  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;

  logic [1:0]       arready, rvalid, rlast;
  logic [1:0][31:0] rdata;
  logic [1:0][1:0]  rresp;
  assign arready = {S1_ARREADY, S0_ARREADY};
  assign rvalid  = {S1_RVALID, S0_RVALID};
  assign rlast   = {S1_RLAST, S0_RLAST};
  assign rdata   = {S1_RDATA, S0_RDATA};
  assign rresp   = {S1_RRESP, S0_RRESP};

  axi_read_arbiter #(.C_ADDRESS_WIDTH(32), .C_DATA_WIDTH(32)) dut (
    .CLK(CLK), .RES(RES),
    .S0_ARADDR(req_addr[0]), .S0_ARLEN(req_len[0]), .S0_ARSIZE(req_size[0]),
    .S0_ARBURST(req_burst[0]), .S0_ARVALID(arvalid[0]), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST),
    .S0_RVALID(S0_RVALID), .S0_RREADY(rready[0]),
    .S1_ARADDR(req_addr[1]), .S1_ARLEN(req_len[1]), .S1_ARSIZE(req_size[1]),
    .S1_ARBURST(req_burst[1]), .S1_ARVALID(arvalid[1]), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST),
    .S1_RVALID(S1_RVALID), .S1_RREADY(rready[1]),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  logic  m_last;   // model of the previous winner

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int exp_pick(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
      return 0;
`else
      return m_last ? 0 : 1;
`endif
    end
    return v[1] ? 1 : 0;
  endfunction

  task automatic set_req(input int g, input logic [31:0] a, input logic [7:0] l);
    req_addr[g]  = a;
    req_len[g]   = l;
    req_size[g]  = (g == 1) ? 3'd3 : 3'd2;
    req_burst[g] = (g == 1) ? 2'b10 : BURST_INCR;
    arvalid[g]   = 1'b1;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    m_last = 1'b1;
  endtask

  // Runs one burst for requester g, starting at a negedge in IDLE with the
  // request already raised. Returns at a negedge with the arbiter in IDLE.
  task automatic burst(input int g, input int stall, input int bp_lo,
                       input int bp_hi, input int abort_at);
    logic [1:0]  oh;
    logic [31:0] a;
    int          len;
    int          rx;
    beat_t       e;
    beat_t       got;
    oh  = (g == 1) ? 2'b10 : 2'b01;
    a   = req_addr[g];
    len = int'(req_len[g]);
    rx  = 0;
    #1;
    chk("arready_grant", 64'(arready), 64'(oh));
    @(negedge CLK);
    arvalid[g]    = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b1;   // stray beat while in ADDR
    M_AXI_RDATA   = 32'hDEAD_BEEF;
    #1;
    chk("arvalid_addr", 64'(M_AXI_ARVALID), 64'd1);
    chk("araddr", 64'(M_AXI_ARADDR), 64'(a));
    chk("arlen", 64'(M_AXI_ARLEN), 64'(req_len[g]));
    chk("arsize", 64'(M_AXI_ARSIZE), 64'(req_size[g]));
    chk("arburst", 64'(M_AXI_ARBURST), 64'(req_burst[g]));
    chk("stray_addr_rvalid", 64'(rvalid), 64'd0);
    chk("stray_addr_rready", 64'(M_AXI_RREADY), 64'd0);
    chk("arready_addr", 64'(arready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      #1;
      chk("araddr_stall", 64'(M_AXI_ARADDR), 64'(a));
      chk("arvalid_stall", 64'(M_AXI_ARVALID), 64'd1);
    end
    M_AXI_RVALID  = 1'b0;
    M_AXI_ARREADY = 1'b1;
    @(negedge CLK);
    M_AXI_ARREADY = 1'b0;
    #1;
    chk("arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
    for (int b = 0; b <= len; b++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = (a + 32'(b * 4)) ^ ((g == 1) ? 32'hA5A5_0000 : 32'h0);
      M_AXI_RRESP  = 2'(b);           // cycles through OKAY..DECERR
      M_AXI_RLAST  = (b == len);
      e.data = M_AXI_RDATA;
      e.resp = M_AXI_RRESP;
      e.last = M_AXI_RLAST;
      sb.push_back(e);
      if (b == abort_at) begin
        rready[g] = 1'b1;
        RES = 1'b1;
        @(negedge CLK);
        #1;
        chk("rst_rready", 64'(M_AXI_RREADY), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("rst_beats_rx", 64'(rx), 64'(abort_at));
        RES          = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        rready[g]    = 1'b0;
        sb.delete();
        m_last = 1'b1;
        @(negedge CLK);
        return;
      end
      if (b >= bp_lo && b <= bp_hi) begin
        rready[g] = 1'b0;
        #1;
        chk("bp_rready", 64'(M_AXI_RREADY), 64'd0);
        chk("bp_rvalid", 64'(rvalid), 64'(oh));
        @(negedge CLK);
      end
      rready[g] = 1'b1;
      #1;
      chk("rready_mirror", 64'(M_AXI_RREADY), 64'd1);
      chk("rvalid_onehot", 64'(rvalid), 64'(oh));
      chk("arready_data", 64'(arready), 64'd0);
      got.data = rdata[g];
      got.resp = rresp[g];
      got.last = rlast[g];
      if (sb.size() == 0) chk("sb_empty", 64'd0, 64'd1);
      else chk("beat", 64'(got), 64'(sb.pop_front()));
      rx++;
      @(negedge CLK);
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    rready[g]    = 1'b0;
    chk("beats_rx", 64'(rx), 64'(len + 1));
`ifndef ARB_FIXED_PRIO_EN
    m_last = g[0];
`endif
  endtask

  initial begin
    int g;
    arvalid = '0;
    rready  = '0;
    for (int p = 0; p < 2; p++) begin
      req_addr[p] = '0; req_len[p] = '0; req_size[p] = '0; req_burst[p] = '0;
    end
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = RESP_OKAY;
    m_last = 1'b1;
    RES = 1'b1;
    repeat (3) @(negedge CLK);

    // reset state (request held during reset must not be acknowledged)
    arvalid[0] = 1'b1;
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_m_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst_m_rready", 64'(M_AXI_RREADY), 64'd0);
    chk("rst_s_rvalid", 64'(rvalid), 64'd0);
    chk("rst_araddr", 64'(M_AXI_ARADDR), 64'd0);
    chk("rst_arlen", 64'(M_AXI_ARLEN), 64'd0);
    arvalid = '0;
    RES = 1'b0;
    @(negedge CLK);

    // single requester, 16 beats
    set_req(0, 32'h0000_1000, 8'd15);
    burst(0, 0, -1, -1, -1);

    // simultaneous request right after reset: S0 first, then S1
    do_reset();
    set_req(0, 32'h0000_2000, 8'd3);
    set_req(1, 32'h0000_3000, 8'd3);
    g = exp_pick(arvalid);
    burst(g, 0, -1, -1, -1);
    burst(1 - g, 0, -1, -1, -1);

    // back-pressure: 5 AR stall cycles, RREADY low on beats 3..5
    set_req(0, 32'h0000_4000, 8'd7);
    set_req(1, 32'h0000_4800, 8'd7);
    g = exp_pick(arvalid);
    burst(g, 5, 2, 4, -1);
    burst(1 - g, 0, -1, -1, -1);

    // stray memory data in IDLE
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST  = 1'b1;
    rready       = 2'b11;
    repeat (2) begin
      #1;
      chk("stray_idle_rvalid", 64'(rvalid), 64'd0);
      chk("stray_idle_rready", 64'(M_AXI_RREADY), 64'd0);
      @(negedge CLK);
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    rready       = 2'b00;

    // reset at beat 7 of 16, then a fresh S1 request
    set_req(0, 32'h0000_5000, 8'd15);
    burst(0, 0, -1, -1, 6);
    set_req(1, 32'h0000_6000, 8'd3);
    burst(1, 0, -1, -1, -1);

    // both requesting continuously for 3 bursts
    set_req(0, 32'h0000_7000, 8'd1);
    set_req(1, 32'h0000_7800, 8'd1);
    for (int i = 0; i < 3; i++) begin
      g = exp_pick(arvalid);
      burst(g, 0, -1, -1, -1);
      set_req(g, 32'h0000_8000 + 32'(i * 32'h100) + 32'(g * 32'h80), 8'd1);
    end
    arvalid = '0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
